reg_share_arbiter: RTL and testbench

- Round-robin arbiter that shares one WIDTH-bit storage register (bank of D flip-flops) between NREQ requesters.
- Grants exclusive, bounded-length write ownership via a req/gnt handshake.
- Drives the shared register contents to all consumers.
- Sits between multiple producer blocks and the single shared state register in the datapath.

---
 rtl/reg_share_arbiter.sv | 111 +++++++++++
 tb/tb_reg_share_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/reg_share_arbiter.sv
// Round-robin owner arbitration for one shared WIDTH-bit register; grant 1 edge after req, held <= MAX_HOLD cycles.
// No backpressure: non-owner writes and writes outside GRANT are dropped, q holds until the owner writes.
module reg_share_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       wr_en,
  input  logic [NREQ*WIDTH-1:0] wr_data,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic                  q_valid,
  output logic                  busy
);

  localparam int LW = $clog2(NREQ);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [LW-1:0]     last_q, last_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;

  logic [LW-1:0]     win;
  logic              found;
  int                idx;

  // Scan starting just past the previous owner so every waiter is served in turn.
  always_comb begin
    win   = last_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = LW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    hold_d  = hold_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          last_d     = win;
          hold_d     = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        // last_q is the current owner; its write lands even on the edge it drops req.
        if (wr_en[last_q]) begin
          data_d  = wr_data[int'(last_q)*WIDTH +: WIDTH];
          valid_d = 1'b1;
        end
        if (!req[last_q] || hold_q == HOLD_LAST) begin
          gnt_d   = '0;
          state_d = RELEASE;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      RELEASE: state_d = IDLE;
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= LW'(NREQ - 1);
      hold_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign gnt     = gnt_q;
  assign q       = data_q;
  assign q_valid = valid_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Bench for reg_share_arbiter: vector table plus generated round-robin/hog sequences and an async reset probe.
module tb_reg_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  wr_en;
  logic [31:0] wr_data;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        q_valid;
  logic        busy;

  reg_share_arbiter #(.NREQ(4), .WIDTH(8), .MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .gnt     (gnt),
    .q       (q),
    .q_valid (q_valid),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  wen;
    logic [31:0] wd;
    logic [3:0]  g;
    logic [7:0]  q;
    logic        v;
    logic        b;
  } vec_t;

  typedef struct packed {
    logic [3:0] g;
    logic [7:0] q;
    logic       v;
    logic       b;
  } exp_t;

  vec_t  tbl[$];
  exp_t  sb[$];
  string sb_tag[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, expv);
    end
  endtask

  // Expected outputs are queued with the stimulus and retired after the edge.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    exp_t got;
    string t;
    sb.push_back('{g: v.g, q: v.q, v: v.v, b: v.b});
    sb_tag.push_back(tag);
    rst     = v.rst;
    req     = v.req;
    wr_en   = v.wen;
    wr_data = v.wd;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e   = sb.pop_front();
      t   = sb_tag.pop_front();
      got = '{g: gnt, q: q, v: q_valid, b: busy};
      check({t, "_gnt"},   32'(got.g), 32'(e.g));
      check({t, "_q"},     32'(got.q), 32'(e.q));
      check({t, "_valid"}, 32'(got.v), 32'(e.v));
      check({t, "_busy"},  32'(got.b), 32'(e.b));
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; wr_en = '0; wr_data = '0;

    // reset and idle, including writes while idle
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 32'h0,          4'b0000, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 32'h0,          4'b0000, 8'h00, 1'b0, 1'b0});
    for (int i = 0; i < 4; i++)
      tbl.push_back('{1'b0, 4'b0000, 4'b0000, 32'h0,        4'b0000, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b1111, 32'hFFFF_FFFF,  4'b0000, 8'h00, 1'b0, 1'b0});
    // single owner (requester 1)
    tbl.push_back('{1'b0, 4'b0010, 4'b0000, 32'h0,          4'b0010, 8'h00, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 4'b0010, 4'b0010, 32'h0000_A500,  4'b0010, 8'hA5, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 4'b0010, 32'h0000_3C00,  4'b0000, 8'h3C, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 4'b0010, 32'h0000_7700,  4'b0000, 8'h3C, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0010, 32'h0000_9900,  4'b0000, 8'h3C, 1'b1, 1'b0});
    // foreign writes rejected, forced release of requester 0 while still requesting
    tbl.push_back('{1'b0, 4'b0001, 4'b0000, 32'h0022_115C,  4'b0001, 8'h3C, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'b0001, 4'b0110, 32'h0022_115C,  4'b0001, 8'h3C, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'b0001, 4'b0001, 32'h0022_115C,  4'b0001, 8'h5C, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'b0001, 4'b0000, 32'h0,          4'b0001, 8'h5C, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'b0001, 4'b0000, 32'h0,          4'b0000, 8'h5C, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'b0001, 4'b0000, 32'h0,          4'b0000, 8'h5C, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b0001, 4'b0000, 32'h0,          4'b0001, 8'h5C, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 32'h0,          4'b0000, 8'h5C, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 32'h0,          4'b0000, 8'h5C, 1'b1, 1'b0});
    // synchronous-style reset back to requester 0 priority
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 32'h0,          4'b0000, 8'h00, 1'b0, 1'b0});

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // all four requesting: 4-cycle grants, 2-cycle gaps, order 0,1,2,3,0
    for (int t = 0; t < 30; t++) begin
      vec_t v;
      v = '{1'b0, 4'b1111, 4'b0000, 32'h0, 4'b0000, 8'h00, 1'b0, 1'b0};
      v.g = ((t % 6) < 4) ? 4'(1 << ((t / 6) % 4)) : 4'b0000;
      v.b = ((t % 6) != 5);
      apply(v, $sformatf("rr%0d", t));
    end

    // lone hog on requester 2
    for (int t = 0; t < 24; t++) begin
      vec_t v;
      v = '{1'b0, 4'b0100, 4'b0000, 32'h0, 4'b0000, 8'h00, 1'b0, 1'b0};
      v.g = ((t % 6) < 4) ? 4'b0100 : 4'b0000;
      v.b = ((t % 6) != 5);
      apply(v, $sformatf("hog%0d", t));
    end

    // async reset in the second cycle of a grant to requester 3
    apply('{1'b0, 4'b1000, 4'b0000, 32'h0,         4'b1000, 8'h00, 1'b0, 1'b1}, "ar_grant");
    apply('{1'b0, 4'b1000, 4'b1000, 32'hE700_0000, 4'b1000, 8'hE7, 1'b1, 1'b1}, "ar_write");
    rst = 1'b1;
    #1;
    check("ar_now_gnt",   32'(gnt),     32'h0);
    check("ar_now_q",     32'(q),       32'h0);
    check("ar_now_valid", 32'(q_valid), 32'h0);
    check("ar_now_busy",  32'(busy),    32'h0);
    apply('{1'b1, 4'b1001, 4'b0000, 32'h0, 4'b0000, 8'h00, 1'b0, 1'b0}, "ar_held");
    apply('{1'b0, 4'b1001, 4'b0000, 32'h0, 4'b0001, 8'h00, 1'b0, 1'b1}, "ar_first");
    apply('{1'b0, 4'b0000, 4'b0000, 32'h0, 4'b0000, 8'h00, 1'b0, 1'b1}, "ar_rel");
    apply('{1'b0, 4'b0000, 4'b0000, 32'h0, 4'b0000, 8'h00, 1'b0, 1'b0}, "ar_idle");

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
